// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/execute control with jump, call/return
// and branch next-PC selection over a small return stack.
module pc_sequencer #(
   parameter logic [6:0] RESET_PC = 7'd0,
   parameter int         RS_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       halt_req,
   output logic       imem_req,
   input  logic       imem_ack,
   output logic [6:0] pc,
   output logic       instr_valid,
   input  logic       stall,
   input  logic       jmp,
   input  logic       call,
   input  logic       ret,
   input  logic       br_taken,
   input  logic [6:0] tgt,
   output logic       busy,
   output logic       stk_err
);

   localparam int CNT_W = $clog2(RS_DEPTH + 1);
   localparam int IDX_W = $clog2(RS_DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] EXEC  = 2'd2;
   localparam logic [1:0] HALT  = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [6:0]       stack [RS_DEPTH];

   logic [6:0]       next_pc;
   logic [CNT_W-1:0] next_cnt;
   logic             do_push;
   logic             err_set;
   logic [IDX_W-1:0] top_idx;
   logic [IDX_W-1:0] push_idx;
   logic             retire;

   function automatic logic [6:0] pc_inc(input logic [6:0] v);
      return v + 7'd1;
   endfunction

   assign top_idx  = IDX_W'(cnt - CNT_W'(1));
   assign push_idx = IDX_W'(cnt);
   assign retire   = (state == EXEC) && !stall;

   // Outputs decode from registered state only; no input reaches an output.
   assign imem_req    = (state == FETCH);
   assign instr_valid = (state == EXEC);
   assign busy        = (state == FETCH) || (state == EXEC);

   // Next-PC priority: jmp > call > ret > br_taken > sequential.
   always_comb begin
      next_pc  = pc_inc(pc);
      next_cnt = cnt;
      do_push  = 1'b0;
      err_set  = 1'b0;
      if (jmp) begin
         next_pc = tgt;
      end else if (call) begin
         next_pc = tgt;
         if (cnt == CNT_W'(RS_DEPTH)) begin
            err_set = 1'b1;
         end else begin
            do_push  = 1'b1;
            next_cnt = cnt + CNT_W'(1);
         end
      end else if (ret) begin
         if (cnt == '0) begin
            err_set = 1'b1;
         end else begin
            next_pc  = stack[top_idx];
            next_cnt = cnt - CNT_W'(1);
         end
      end else if (br_taken) begin
         next_pc = tgt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         cnt     <= '0;
         stk_err <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (start) state <= FETCH;
            FETCH:   if (imem_ack) state <= EXEC;
            EXEC: begin
               if (!stall) begin
                  pc    <= next_pc;
                  cnt   <= next_cnt;
                  state <= halt_req ? HALT : FETCH;
                  if (err_set) stk_err <= 1'b1;
               end
            end
            default: if (start) state <= FETCH;
         endcase
      end
   end

   // Stack entries are plain storage; validity is tracked by cnt alone.
   always_ff @(posedge clk) begin
      if (retire && do_push) stack[push_idx] <= pc_inc(pc);
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected EXEC-cycle PCs are queued as
// each instruction is issued and popped whenever the DUT asserts instr_valid.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, start, halt_req, imem_req, imem_ack;
   logic [6:0] pc;
   logic       instr_valid, stall, jmp, call, ret, br_taken;
   logic [6:0] tgt;
   logic       busy, stk_err;

   int n_cmp = 0;
   int n_err = 0;
   int iv_cnt = 0;

   logic [6:0] sb_q [$];
   logic [6:0] mstk [$];
   logic [6:0] mpc;
   logic       merr;

   pc_sequencer #(.RESET_PC(7'd0), .RS_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
      .imem_req(imem_req), .imem_ack(imem_ack), .pc(pc),
      .instr_valid(instr_valid), .stall(stall), .jmp(jmp), .call(call),
      .ret(ret), .br_taken(br_taken), .tgt(tgt), .busy(busy),
      .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Pop one expected PC per EXEC cycle, stalled cycles included.
   always @(negedge clk) begin
      if (instr_valid === 1'b1) begin
         iv_cnt++;
         if (sb_q.size() == 0) begin
            check("sb_underrun", sb_q.size(), 1);
         end else begin
            check("exec_pc", pc, sb_q.pop_front());
         end
      end
   end

   task automatic model_step(input logic j, c, r, b, input logic [6:0] t);
      if (j) mpc = t;
      else if (c) begin
         if (mstk.size() < 4) mstk.push_back(mpc + 7'd1);
         else merr = 1'b1;
         mpc = t;
      end else if (r) begin
         if (mstk.size() > 0) mpc = mstk.pop_back();
         else begin
            merr = 1'b1;
            mpc  = mpc + 7'd1;
         end
      end else if (b) mpc = t;
      else mpc = mpc + 7'd1;
   endtask

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   // Expects the DUT in FETCH; acks after ack_dly cycles, stalls nstall cycles.
   task automatic do_instr(input logic j, c, r, b, input logic [6:0] t,
                           input logic h, input int nstall, input int ack_dly);
      for (int i = 0; i < ack_dly; i++) begin
         cycle();
         check("fetch_hold_req", imem_req, 1);
         check("fetch_hold_pc", pc, mpc);
      end
      check("fetch_req", imem_req, 1);
      for (int i = 0; i <= nstall; i++) sb_q.push_back(mpc);
      imem_ack = 1'b1;
      cycle();
      imem_ack = 1'b0;
      jmp = j; call = c; ret = r; br_taken = b; tgt = t; halt_req = h;
      for (int i = 0; i < nstall; i++) begin
         stall = 1'b1;
         cycle();
      end
      stall = 1'b0;
      cycle();
      jmp = 0; call = 0; ret = 0; br_taken = 0; tgt = 7'd0; halt_req = 0;
      model_step(j, c, r, b, t);
      check("next_pc", pc, mpc);
      check("stk_err", stk_err, merr);
      check("busy_after", busy, !h);
   endtask

   task automatic seq(input logic h);
      do_instr(0, 0, 0, 0, 7'd0, h, 0, 0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      cycle();
      mpc = 7'd0; merr = 1'b0; mstk.delete();
      check("rst_req", imem_req, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_pc", pc, 0);
      check("rst_err", stk_err, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int iv0;
      rst_n = 0; start = 0; halt_req = 0; imem_ack = 0; stall = 0;
      jmp = 0; call = 0; ret = 0; br_taken = 0; tgt = 0;
      mpc = 0; merr = 0;
      cycle();
      apply_reset();

      // Idle must ignore ack and wait for start.
      imem_ack = 1'b1;
      cycle();
      imem_ack = 1'b0;
      cycle();
      check("idle_req", imem_req, 0);
      check("idle_busy", busy, 0);
      start = 1'b1;
      cycle();
      start = 1'b0;
      check("start_fetch", imem_req, 1);
      check("start_busy", busy, 1);

      // Sequential run, then halt at pc 3.
      iv0 = iv_cnt;
      seq(0); seq(0); seq(0);
      check("iv_every_2nd", iv_cnt - iv0, 3);
      seq(1);
      check("halt_req_low", imem_req, 0);
      cycle();
      check("halt_pc_hold", pc, 4);
      check("halt_busy", busy, 0);
      start = 1'b1;
      cycle();
      start = 1'b0;
      check("resume_req", imem_req, 1);
      check("resume_pc", pc, 4);

      // Wrap and branch, with a delayed ack.
      do_instr(1, 0, 0, 0, 7'd127, 0, 0, 0);
      do_instr(0, 0, 0, 0, 7'd0, 0, 0, 2);
      do_instr(0, 0, 0, 1, 7'd40, 0, 0, 0);

      // Call/return.
      do_instr(1, 0, 0, 0, 7'd5, 0, 0, 0);
      do_instr(0, 1, 0, 0, 7'd20, 0, 0, 0);
      do_instr(0, 0, 1, 0, 7'd0, 0, 0, 0);

      // Five nested calls overflow on the fifth.
      for (int i = 0; i < 5; i++) do_instr(0, 1, 0, 0, 7'(30 + i), 0, 0, 0);
      for (int i = 0; i < 5; i++) do_instr(0, 0, 1, 0, 7'd0, 0, 0, 0);

      // Priority: jmp+call must not push; ret beats br_taken.
      do_instr(1, 0, 0, 0, 7'd60, 0, 0, 0);
      do_instr(0, 1, 0, 0, 7'd50, 0, 0, 0);
      do_instr(1, 1, 0, 0, 7'd9, 0, 0, 0);
      do_instr(0, 0, 1, 1, 7'd100, 0, 0, 0);
      do_instr(0, 0, 1, 0, 7'd0, 0, 0, 0);

      // Stall 3 cycles with jmp held: pc frozen, instr_valid 4 cycles.
      iv0 = iv_cnt;
      do_instr(1, 0, 0, 0, 7'd77, 0, 3, 0);
      check("stall_iv_cycles", iv_cnt - iv0, 4);

      // Reset during FETCH with ack pending.
      check("pre_rst_fetch", imem_req, 1);
      imem_ack = 1'b1;
      apply_reset();
      imem_ack = 1'b0;
      cycle();
      check("post_rst_idle", imem_req, 0);
      check("post_rst_pc", pc, 0);

      // Underflow on a fresh stack.
      start = 1'b1;
      cycle();
      start = 1'b0;
      do_instr(0, 0, 1, 0, 7'd0, 0, 0, 0);
      check("underflow_pc", pc, 1);
      seq(0);
      check("err_sticky", stk_err, 1);

      cycle();
      check("sb_left", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 7'd0, meaning the PC value loaded at reset.
REQ-002 The block SHALL have parameter RS_DEPTH, default 4, meaning the number of return-stack entries (fixed at 4 in this revision).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  begin or resume fetching; sampled in IDLE and HALT only.
REQ-006 halt_req  input  1  stop after the current instruction completes; sampled in EXEC.
REQ-007 imem_req  output  1  fetch request to instruction memory at address pc.
REQ-008 imem_ack  input  1  instruction memory returns a word; honoured only in FETCH.
REQ-009 pc  output  7  current program counter.
REQ-010 instr_valid  output  1  high for exactly the EXEC cycle.
REQ-011 stall  input  1  hold in EXEC; no PC update.
REQ-012 jmp, call, ret, br_taken  input  1 each  next-PC control, sampled in EXEC.
REQ-013 tgt  input  7  target for jmp, call and br_taken.
REQ-014 busy  output  1  high in FETCH and EXEC.
REQ-015 stk_err  output  1  sticky return-stack overflow or underflow flag.

Function
REQ-016 The block SHALL implement four states: IDLE=0, FETCH=1, EXEC=2, HALT=3.
REQ-017 IDLE: imem_req=0; start=1 -> FETCH next cycle.
REQ-018 FETCH: imem_req=1 and pc stable; imem_ack=1 -> EXEC next cycle; otherwise remain in FETCH indefinitely (no timeout).
REQ-019 EXEC lasts one cycle unless stall=1, in which case the block remains in EXEC with pc, stack and all outputs unchanged, and instr_valid stays 1.
REQ-020 In EXEC with stall=0, next pc SHALL be selected with priority jmp > call > ret > br_taken > sequential.
- jmp: pc<=tgt.
- call: push (pc+1) mod 128, then pc<=tgt.
- ret: pc<=pop.
- br_taken: pc<=tgt.
- sequential: pc<=(pc+1) mod 128.
REQ-021 Increment SHALL be 7-bit with wrap: 7'd127 -> 7'd0; no carry output.
REQ-022 Lower-priority controls asserted in the same cycle as a higher-priority one SHALL be ignored and SHALL have no side effects (e.g. call+jmp performs no push).
REQ-023 After the EXEC update with stall=0: halt_req=1 -> HALT; otherwise -> FETCH.
REQ-024 HALT: imem_req=0, busy=0, pc retained; start=1 -> FETCH at the retained pc.
REQ-025 Return stack: LIFO, count 0..4.
- Push when full: stk_err<=1, entry dropped, stack unchanged, jump still taken.
- Pop when empty: stk_err<=1, pc<=(pc+1) mod 128.
REQ-026 stk_err SHALL remain set until reset.
REQ-027 imem_ack outside FETCH and start outside IDLE/HALT SHALL be ignored.
REQ-028 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational input-to-output path.

Reset
REQ-029 When rst_n=0 at a rising edge, in any state including mid-FETCH or stalled EXEC, the block SHALL enter IDLE with pc=RESET_PC, stack count 0 and stk_err=0.
REQ-030 While in reset: imem_req=0, instr_valid=0, busy=0.
REQ-031 In the first cycle after rst_n returns to 1, the block SHALL be in IDLE and SHALL require start before fetching.

Verification
REQ-032 Sequential run: reset, start, imem_ack=1 every FETCH -> pc sequence 0,1,2,3; instr_valid every second cycle; FETCH-to-EXEC latency 1 cycle after ack.
REQ-033 Wrap and branch: pc=127, no control -> pc=0; then br_taken=1, tgt=7'd40 -> pc=40.
REQ-034 Call/ret: at pc=5, call tgt=20 -> pc=20; ret -> pc=6.
- Five nested calls -> fifth sets stk_err=1.
- Ret with an empty stack -> pc+1, stk_err=1.
REQ-035 Priority and stall:
- jmp=1, call=1, tgt=9 -> pc=9 with stack count unchanged.
- stall held 3 cycles in EXEC -> pc constant, instr_valid high for 4 cycles total.
REQ-036 Halt and reset:
- halt_req in EXEC at pc=3 -> pc=4, HALT; start -> FETCH at 4.
- rst_n=0 during FETCH with ack pending -> next cycle IDLE, pc=0, imem_req=0.
